exec_top: RTL and testbench

EXEC_TOP -- requirements
Module: exec_top

---
 rtl/exec_pkg.sv | 31 +++
 rtl/exec_md_unit.sv | 102 ++++++++++
 rtl/exec_top.sv | 113 +++++++++++
 tb/tb_exec_top.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU op select, multiply/divide op
// and the multiply/divide sequencer state.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        MD_MUL   = 2'd0,
        MD_MULHU = 2'd1,
        MD_DIVU  = 2'd2,
        MD_REMU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/exec_md_unit.sv
// Iterative unsigned multiply/divide: one shift-add or restoring-subtract
// step per cycle, DATA_WIDTH steps, then a single-cycle DONE.
module md_unit
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    state_e                state_q, state_d;
    md_op_e                op_q, op_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH:0]   sum, shifted, diff;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        shifted = {hi_q, lo_q[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, a_q};

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d  = md_op_e'(op_i);
                    cnt_d = CW'(DATA_WIDTH);
                    hi_d  = '0;
                    // Divide keeps the dividend in lo and the divisor in a.
                    if (op_i[1]) begin
                        a_d  = b_i;
                        lo_d = a_i;
                    end else begin
                        a_d  = a_i;
                        lo_d = b_i;
                    end
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == MD_MUL || op_q == MD_MULHU) begin
                    hi_d = sum[DATA_WIDTH:1];
                    lo_d = {sum[0], lo_q[DATA_WIDTH-1:1]};
                end else if (!diff[DATA_WIDTH]) begin
                    hi_d = diff[DATA_WIDTH-1:0];
                    lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shifted[DATA_WIDTH-1:0];
                    lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= MD_MUL;
            cnt_q   <= '0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Divide by zero needs no special case: every step "subtracts" zero,
    // so the quotient fills with ones and hi accumulates the dividend.
    assign busy_o   = (state_q == ST_BUSY);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = (op_q == MD_MUL || op_q == MD_DIVU) ? lo_q : hi_q;

endmodule

// File: rtl/exec_top.sv
// Execute stage: register file, single-cycle ALU and an iterative
// multiply/divide unit that stalls instruction acceptance while running.
module exec_top
    import exec_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] rs1_i,
    input  logic [ADDR_WIDTH-1:0] rs2_i,
    input  logic [ADDR_WIDTH-1:0] rd_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  md_i,
    input  logic [1:0]            md_op_i,
    input  logic                  reg_write_i,
    input  logic                  reg_write_src_i,
    input  logic                  alu_src_i,
    input  logic [DATA_WIDTH-1:0] imm_op_i,
    input  logic [DATA_WIDTH-1:0] mem_read_val_i,
    input  logic [3:0]            alu_ctrl_i,
    output logic                  eq_o,
    output logic [DATA_WIDTH-1:0] a0_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  done_o
);

    localparam int unsigned NREG = 2 ** ADDR_WIDTH;
    localparam int          SW   = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic [DATA_WIDTH-1:0] regs_d [NREG];
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                  wr_q, wr_d;

    logic [DATA_WIDTH-1:0] rs1_val, rs2_val, op2, alu_res, md_result, wb_val;
    logic [SW-1:0]         shamt;
    logic                  md_start, md_busy, md_done, alu_wr;

    assign rs1_val = (rs1_i == '0) ? '0 : regs_q[rs1_i];
    assign rs2_val = (rs2_i == '0) ? '0 : regs_q[rs2_i];
    assign op2     = alu_src_i ? imm_op_i : rs2_val;
    assign shamt   = op2[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_ctrl_e'(alu_ctrl_i))
            ALU_ADD:  alu_res = rs1_val + op2;
            ALU_SUB:  alu_res = rs1_val - op2;
            ALU_AND:  alu_res = rs1_val & op2;
            ALU_OR:   alu_res = rs1_val | op2;
            ALU_XOR:  alu_res = rs1_val ^ op2;
            ALU_SLL:  alu_res = rs1_val << shamt;
            ALU_SRL:  alu_res = rs1_val >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(rs1_val) >>> shamt);
            ALU_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1_val) < $signed(op2))};
            ALU_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (rs1_val < op2)};
            default:  alu_res = '0;
        endcase
    end

    md_unit #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_md (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (md_start),
        .op_i    (md_op_i),
        .a_i     (rs1_val),
        .b_i     (op2),
        .busy_o  (md_busy),
        .done_o  (md_done),
        .result_o(md_result)
    );

    assign ready_o  = !(md_busy || md_done);
    assign md_start = ready_o && valid_i && md_i;
    assign alu_wr   = ready_o && valid_i && !md_i && reg_write_i && (rd_i != '0);
    assign wb_val   = reg_write_src_i ? mem_read_val_i : alu_res;

    always_comb begin
        regs_d = regs_q;
        rd_d   = md_start ? rd_i : rd_q;
        wr_d   = md_start ? reg_write_i : wr_q;
        if (alu_wr) begin
            regs_d[rd_i] = wb_val;
        end else if (md_done && wr_q && (rd_q != '0)) begin
            regs_d[rd_q] = md_result;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            rd_q <= '0;
            wr_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
        end
    end

    assign eq_o     = (alu_res == '0);
    assign result_o = md_done ? md_result : alu_res;
    assign done_o   = md_done;
    assign a0_o     = regs_q[10];

endmodule

// File: tb/tb_exec_top.sv
// Directed bench for exec_top: ALU vector table plus hand-written
// multiply/divide, stall and reset-abort sequences.
module tb_exec_top;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic        valid, ready_o, md;
    logic [1:0]  md_op;
    logic        reg_write, src, alu_src;
    logic [31:0] imm, mem;
    logic [3:0]  ctrl;
    logic        eq_o, done_o;
    logic [31:0] a0_o, result_o;

    exec_top #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .valid_i(valid), .ready_o(ready_o), .md_i(md), .md_op_i(md_op),
        .reg_write_i(reg_write), .reg_write_src_i(src), .alu_src_i(alu_src),
        .imm_op_i(imm), .mem_read_val_i(mem), .alu_ctrl_i(ctrl),
        .eq_o(eq_o), .a0_o(a0_o), .result_o(result_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        alu_src;
        logic [3:0]  ctrl;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t vecs [15];
    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [31:0] v);
        valid = 1'b0; rs1 = a; alu_src = 1'b1; imm = '0; ctrl = 4'd0;
        #1 v = result_o;
    endtask

    task automatic load_reg(input logic [4:0] d, input logic [31:0] val);
        @(negedge clk);
        valid = 1'b1; md = 1'b0; reg_write = 1'b1; src = 1'b1; mem = val; rd = d;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; reg_write = 1'b0; src = 1'b0;
    endtask

    // Issues one M/D op and follows it until ready returns (bounded).
    task automatic md_run(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d, output logic [31:0] res,
                          output int dk, output int low, output int nd);
        @(negedge clk);
        rs1 = a; rs2 = b; rd = d; md_op = op; md = 1'b1; alu_src = 1'b0;
        reg_write = 1'b1; src = 1'b0; valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; md = 1'b0; reg_write = 1'b0;
        res = 'x; dk = -1; low = 0; nd = 0;
        for (int k = 1; k <= 100; k++) begin
            #1;
            if (done_o) begin
                nd++; dk = k; res = result_o;
            end
            if (ready_o) break;
            low++;
            @(negedge clk);
        end
    endtask

    logic [31:0] v, res;
    int dk, low, nd;

    initial begin
        rst = 1'b1; valid = 1'b0; md = 1'b0; md_op = 2'd0; rs1 = '0; rs2 = '0; rd = '0;
        reg_write = 1'b0; src = 1'b0; alu_src = 1'b0; imm = '0; mem = '0; ctrl = '0;

        vecs[0]  = '{32'd5,         32'd7,         32'd0,     1'b0, 4'd0,  32'd12};
        vecs[1]  = '{32'd7,         32'd7,         32'd0,     1'b0, 4'd1,  32'd0};
        vecs[2]  = '{32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0,     1'b0, 4'd2,  32'h00F0_1234};
        vecs[3]  = '{32'hF000_0000, 32'h0000_000F, 32'd0,     1'b0, 4'd3,  32'hF000_000F};
        vecs[4]  = '{32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0,     1'b0, 4'd4,  32'hF0F0_0F0F};
        vecs[5]  = '{32'd1,         32'd35,        32'd0,     1'b0, 4'd5,  32'd8};
        vecs[6]  = '{32'h8000_0000, 32'd4,         32'd0,     1'b0, 4'd6,  32'h0800_0000};
        vecs[7]  = '{32'h8000_0000, 32'd4,         32'd0,     1'b0, 4'd7,  32'hF800_0000};
        vecs[8]  = '{32'hFFFF_FFFF, 32'd1,         32'd0,     1'b0, 4'd8,  32'd1};
        vecs[9]  = '{32'hFFFF_FFFF, 32'd1,         32'd0,     1'b0, 4'd9,  32'd0};
        vecs[10] = '{32'd123,       32'd45,        32'd0,     1'b0, 4'd12, 32'd0};
        vecs[11] = '{32'd0,         32'd1,         32'd0,     1'b0, 4'd1,  32'hFFFF_FFFF};
        vecs[12] = '{32'hFFFF_FFFF, 32'd1,         32'd0,     1'b0, 4'd0,  32'd0};
        vecs[13] = '{32'd5,         32'd100,       32'h10,    1'b1, 4'd0,  32'h15};
        vecs[14] = '{32'h8000_0000, 32'd31,        32'd0,     1'b0, 4'd7,  32'hFFFF_FFFF};

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_a0", a0_o, 32'd0);
        rst = 1'b0;
        read_reg(5'd1, v); chk("rst_x1", v, 32'd0);

        // ADDI x1 = x0 + 5
        @(negedge clk);
        rs1 = 5'd0; imm = 32'd5; alu_src = 1'b1; ctrl = 4'd0; rd = 5'd1;
        reg_write = 1'b1; src = 1'b0; valid = 1'b1;
        #1;
        chk("addi_eq", {31'd0, eq_o}, 32'd0);
        chk("addi_res", result_o, 32'd5);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; reg_write = 1'b0;
        chk("addi_a0", a0_o, 32'd0);
        read_reg(5'd1, v); chk("addi_x1", v, 32'd5);

        // x1 = x1 + 1: operand read in the write cycle sees the old value
        @(negedge clk);
        rs1 = 5'd1; imm = 32'd1; alu_src = 1'b1; ctrl = 4'd0; rd = 5'd1;
        reg_write = 1'b1; valid = 1'b1;
        #1 chk("inc_old", result_o, 32'd6);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; reg_write = 1'b0;
        read_reg(5'd1, v); chk("inc_x1", v, 32'd6);

        // write to x0 must be dropped
        @(negedge clk);
        rs1 = 5'd0; imm = 32'd9; alu_src = 1'b1; ctrl = 4'd0; rd = 5'd0;
        reg_write = 1'b1; valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; reg_write = 1'b0;
        read_reg(5'd0, v); chk("x0_zero", v, 32'd0);

        for (int i = 0; i < 15; i++) begin
            load_reg(5'd1, vecs[i].a);
            load_reg(5'd2, vecs[i].b);
            rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; alu_src = vecs[i].alu_src;
            imm = vecs[i].imm; ctrl = vecs[i].ctrl; reg_write = 1'b1; src = 1'b0;
            md = 1'b0; valid = 1'b1;
            #1;
            chk($sformatf("alu%0d_res", i), result_o, vecs[i].exp);
            chk($sformatf("alu%0d_eq", i), {31'd0, eq_o}, {31'd0, vecs[i].exp == 32'd0});
            @(posedge clk);
            @(negedge clk);
            valid = 1'b0; reg_write = 1'b0;
            read_reg(5'd3, v);
            chk($sformatf("alu%0d_x3", i), v, vecs[i].exp);
        end

        // MULHU 0xFFFFFFFF * 2 -> x10
        load_reg(5'd1, 32'hFFFF_FFFF);
        load_reg(5'd2, 32'd2);
        md_run(2'd1, 5'd1, 5'd2, 5'd10, res, dk, low, nd);
        chk("mulhu_low_cycles", low, 32'd33);
        chk("mulhu_done_cycle", dk, 32'd33);
        chk("mulhu_done_count", nd, 32'd1);
        chk("mulhu_res", res, 32'd1);
        chk("mulhu_a0", a0_o, 32'd1);

        md_run(2'd0, 5'd1, 5'd2, 5'd11, res, dk, low, nd);
        chk("mul_res", res, 32'hFFFF_FFFE);
        read_reg(5'd11, v); chk("mul_x11", v, 32'hFFFF_FFFE);

        load_reg(5'd1, 32'd100);
        load_reg(5'd2, 32'd7);
        md_run(2'd2, 5'd1, 5'd2, 5'd12, res, dk, low, nd);
        chk("divu_res", res, 32'd14);
        read_reg(5'd12, v); chk("divu_x12", v, 32'd14);
        md_run(2'd3, 5'd1, 5'd2, 5'd13, res, dk, low, nd);
        chk("remu_res", res, 32'd2);
        read_reg(5'd13, v); chk("remu_x13", v, 32'd2);

        load_reg(5'd2, 32'd0);
        md_run(2'd2, 5'd1, 5'd2, 5'd14, res, dk, low, nd);
        chk("divz_res", res, 32'hFFFF_FFFF);
        chk("divz_done_cycle", dk, 32'd33);
        read_reg(5'd14, v); chk("divz_x14", v, 32'hFFFF_FFFF);
        md_run(2'd3, 5'd1, 5'd2, 5'd15, res, dk, low, nd);
        chk("remz_res", res, 32'd100);
        read_reg(5'd15, v); chk("remz_x15", v, 32'd100);

        // MUL x6 = x4 * x5 with valid held high and inputs churning while busy
        load_reg(5'd4, 32'd3);
        load_reg(5'd5, 32'd5);
        @(negedge clk);
        rs1 = 5'd4; rs2 = 5'd5; rd = 5'd6; md = 1'b1; md_op = 2'd0; alu_src = 1'b0;
        reg_write = 1'b1; src = 1'b0; valid = 1'b1;
        @(posedge clk);
        nd = 0; res = 'x;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            #1;
            if (ready_o) break;
            if (done_o) begin
                nd++; res = result_o; valid = 1'b0;
            end else begin
                md = k[0]; md_op = k[1:0]; rd = 5'd7; src = 1'b1;
                mem = 32'hDEAD_0000 + k; ctrl = k[3:0]; valid = 1'b1;
            end
        end
        valid = 1'b0; md = 1'b0; reg_write = 1'b0; src = 1'b0;
        chk("stall_done_count", nd, 32'd1);
        chk("stall_res", res, 32'd15);
        read_reg(5'd6, v); chk("stall_x6", v, 32'd15);
        read_reg(5'd7, v); chk("stall_x7", v, 32'd0);
        read_reg(5'd4, v); chk("stall_x4", v, 32'd3);
        read_reg(5'd5, v); chk("stall_x5", v, 32'd5);

        // Reset in cycle 10 of a DIVU to x5
        load_reg(5'd1, 32'd100);
        load_reg(5'd2, 32'd7);
        @(negedge clk);
        rs1 = 5'd1; rs2 = 5'd2; rd = 5'd5; md = 1'b1; md_op = 2'd2; alu_src = 1'b0;
        reg_write = 1'b1; valid = 1'b1;
        @(posedge clk);
        nd = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            valid = 1'b0; md = 1'b0; reg_write = 1'b0;
            if (done_o) nd++;
        end
        rst = 1'b1;
        #1;
        chk("abort_a0_cleared", a0_o, 32'd0);
        chk("abort_ready_in_rst", {31'd0, ready_o}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("abort_ready_after", {31'd0, ready_o}, 32'd1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done_o) nd++;
        end
        chk("abort_no_done", nd, 32'd0);
        read_reg(5'd5, v); chk("abort_x5", v, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
